rgmii_gmii_rx: RTL and testbench

- RGMII receive path; the receive-direction counterpart of the GMII-to-RGMII transmit converter.
- Captures DDR nibbles and control on rgmii_rxc and rebuilds the GMII byte stream with gmii_rx_dv and gmii_rx_er.
- A framer strips preamble and SFD and emits payload bytes with sof/eof/err marks and the frame length.
- Keeps saturating good/bad frame counters; optionally decodes RGMII in-band link status. Sits between the PHY pins and the MAC receive logic.

---
 rtl/rgmii_gmii_rx.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_rgmii_gmii_rx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_gmii_rx.sv
// ---------------------------------------------------------------------------
// rgmii_gmii_rx
//   RGMII receive path. DDR nibbles and control captured on both edges of
//   rgmii_rxc are rebuilt into a GMII byte stream. A framer strips preamble
//   and SFD, emits payload bytes with sof/eof/err marks and the frame length,
//   and keeps saturating good/bad frame counters.
//
//   Optional build macro RGMII_RX_INBAND_EN: decode RGMII in-band link status
//   from idle nibbles (debounced over two identical nibbles). Without it the
//   link outputs are constant (up, 1000M, full duplex) after reset release.
//
// Ports
//   rgmii_rxc      in   receive clock, both edges used
//   rst_n          in   asynchronous reset, active-low
//   rgmii_rxd      in   DDR data: low nibble rising, high nibble falling
//   rgmii_rx_ctl   in   DDR control: RX_DV rising, RX_DV^RX_ER falling
//   gmii_rxd       out  reconstructed byte
//   gmii_rx_dv     out  GMII data valid
//   gmii_rx_er     out  GMII receive error
//   pay_valid      out  payload byte strobe
//   pay_data       out  payload byte
//   pay_sof        out  first payload byte
//   pay_eof        out  last payload byte
//   pay_err        out  frame bad, qualifies pay_eof
//   pay_len        out  payload byte count, valid with pay_eof
//   frame_ok_cnt   out  good frames, saturating
//   frame_err_cnt  out  bad/dropped frames, saturating
//   link_up        out  in-band link status
//   link_speed     out  00=10M 01=100M 10=1000M
//   link_duplex    out  1=full duplex
// ---------------------------------------------------------------------------
module rgmii_gmii_rx #(
    parameter int CNT_W   = 16,
    parameter int LEN_W   = 16,
    parameter int MAX_LEN = 1522
) (
    input  logic             rgmii_rxc,
    input  logic             rst_n,
    input  logic [3:0]       rgmii_rxd,
    input  logic             rgmii_rx_ctl,
    output logic [7:0]       gmii_rxd,
    output logic             gmii_rx_dv,
    output logic             gmii_rx_er,
    output logic             pay_valid,
    output logic [7:0]       pay_data,
    output logic             pay_sof,
    output logic             pay_eof,
    output logic             pay_err,
    output logic [LEN_W-1:0] pay_len,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic             link_up,
    output logic [1:0]       link_speed,
    output logic             link_duplex
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [3:0]       r_d_q, f_d_q;
    logic             r_c_q, f_c_q;
    logic [7:0]       gmii_rxd_q;
    logic             gmii_dv_q, gmii_er_q;

    state_t           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_v_q, hold_v_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             bad_q, bad_d;
    logic             sent_q, sent_d;
    logic             pv_q, pv_d, psof_q, psof_d, peof_q, peof_d, perr_q, perr_d;
    logic [7:0]       pd_q, pd_d;
    logic [LEN_W-1:0] plen_q, plen_d;
    logic [CNT_W-1:0] ok_cnt_q, err_cnt_q;
    logic             ok_inc_s, err_inc_s, eof_bad_s;
    logic             link_up_q, link_duplex_q;
    logic [1:0]       link_speed_q;

    // Rising-edge capture; GMII byte assembled from the previous rise/fall pair
    always_ff @(posedge rgmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            r_d_q      <= 4'h0;
            r_c_q      <= 1'b0;
            gmii_rxd_q <= 8'h00;
            gmii_dv_q  <= 1'b0;
            gmii_er_q  <= 1'b0;
        end else begin
            r_d_q      <= rgmii_rxd;
            r_c_q      <= rgmii_rx_ctl;
            gmii_rxd_q <= {f_d_q, r_d_q};
            gmii_dv_q  <= r_c_q;
            gmii_er_q  <= r_c_q ^ f_c_q;
        end
    end

    // Falling-edge capture of the high nibble and DV^ER
    always_ff @(negedge rgmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            f_d_q <= 4'h0;
            f_c_q <= 1'b0;
        end else begin
            f_d_q <= rgmii_rxd;
            f_c_q <= rgmii_rx_ctl;
        end
    end

    // Framer next-state and payload outputs
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        len_d     = len_q;
        bad_d     = bad_q;
        sent_d    = sent_q;
        pv_d      = 1'b0;
        pd_d      = pd_q;
        psof_d    = 1'b0;
        peof_d    = 1'b0;
        perr_d    = 1'b0;
        plen_d    = plen_q;
        ok_inc_s  = 1'b0;
        err_inc_s = 1'b0;
        // a frame is bad on a sticky error, oversize or empty payload
        eof_bad_s = bad_q || (len_q > LEN_W'(MAX_LEN)) || (len_q == {LEN_W{1'b0}});
        case (state_q)
            ST_IDLE: begin
                if (gmii_dv_q) begin
                    if (gmii_rxd_q == 8'h55) begin
                        state_d = ST_PRE;
                    end else begin
                        state_d   = ST_DROP;
                        err_inc_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (!gmii_dv_q) begin
                    state_d   = ST_IDLE;
                    err_inc_s = 1'b1;
                end else if (gmii_er_q) begin
                    state_d   = ST_DROP;
                    err_inc_s = 1'b1;
                end else if (gmii_rxd_q == 8'h55) begin
                    state_d = ST_PRE;
                end else if (gmii_rxd_q == 8'hD5) begin
                    state_d  = ST_DATA;
                    hold_v_d = 1'b0;
                    len_d    = {LEN_W{1'b0}};
                    bad_d    = 1'b0;
                    sent_d   = 1'b0;
                end else begin
                    state_d   = ST_DROP;
                    err_inc_s = 1'b1;
                end
            end
            ST_DATA: begin
                if (gmii_dv_q) begin
                    // one-byte delay so the last byte can carry eof
                    if (hold_v_q) begin
                        pv_d   = 1'b1;
                        pd_d   = hold_q;
                        psof_d = !sent_q;
                        sent_d = 1'b1;
                    end else begin
                        sent_d = sent_q;
                    end
                    hold_d   = gmii_rxd_q;
                    hold_v_d = 1'b1;
                    if (len_q != {LEN_W{1'b1}}) begin
                        len_d = len_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    end else begin
                        len_d = len_q;
                    end
                    if (gmii_er_q) begin
                        bad_d = 1'b1;
                    end else begin
                        bad_d = bad_q;
                    end
                end else begin
                    state_d  = ST_IDLE;
                    hold_v_d = 1'b0;
                    if (hold_v_q) begin
                        pv_d      = 1'b1;
                        pd_d      = hold_q;
                        psof_d    = !sent_q;
                        peof_d    = 1'b1;
                        perr_d    = eof_bad_s;
                        plen_d    = len_q;
                        ok_inc_s  = !eof_bad_s;
                        err_inc_s = eof_bad_s;
                    end else begin
                        // SFD directly followed by dv low: nothing to emit
                        err_inc_s = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!gmii_dv_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Framer state, payload output and counter registers
    always_ff @(posedge rgmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hold_q    <= 8'h00;
            hold_v_q  <= 1'b0;
            len_q     <= {LEN_W{1'b0}};
            bad_q     <= 1'b0;
            sent_q    <= 1'b0;
            pv_q      <= 1'b0;
            pd_q      <= 8'h00;
            psof_q    <= 1'b0;
            peof_q    <= 1'b0;
            perr_q    <= 1'b0;
            plen_q    <= {LEN_W{1'b0}};
            ok_cnt_q  <= {CNT_W{1'b0}};
            err_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            len_q     <= len_d;
            bad_q     <= bad_d;
            sent_q    <= sent_d;
            pv_q      <= pv_d;
            pd_q      <= pd_d;
            psof_q    <= psof_d;
            peof_q    <= peof_d;
            perr_q    <= perr_d;
            plen_q    <= plen_d;
            if (ok_inc_s) begin
                ok_cnt_q <= cnt_sat_inc(ok_cnt_q);
            end
            if (err_inc_s) begin
                err_cnt_q <= cnt_sat_inc(err_cnt_q);
            end
        end
    end

`ifdef RGMII_RX_INBAND_EN
    logic [3:0] last_nib_q;
    logic       last_v_q;
    logic       idle_s;
    logic [3:0] nib_s;

    assign idle_s = !gmii_dv_q && !gmii_er_q;
    assign nib_s  = gmii_rxd_q[3:0];

    // In-band status: accept a nibble seen on two consecutive idle cycles
    always_ff @(posedge rgmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            last_nib_q    <= 4'h0;
            last_v_q      <= 1'b0;
            link_up_q     <= 1'b0;
            link_speed_q  <= 2'b10;
            link_duplex_q <= 1'b1;
        end else if (idle_s) begin
            last_nib_q <= nib_s;
            last_v_q   <= 1'b1;
            // speed code 11 is reserved; keep the previous status
            if (last_v_q && (last_nib_q == nib_s) && (nib_s[2:1] != 2'b11)) begin
                link_up_q     <= nib_s[0];
                link_speed_q  <= nib_s[2:1];
                link_duplex_q <= nib_s[3];
            end
        end else begin
            last_v_q <= 1'b0;
        end
    end
`else
    // Fixed link status once out of reset
    always_ff @(posedge rgmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            link_up_q     <= 1'b0;
            link_speed_q  <= 2'b10;
            link_duplex_q <= 1'b1;
        end else begin
            link_up_q     <= 1'b1;
            link_speed_q  <= 2'b10;
            link_duplex_q <= 1'b1;
        end
    end
`endif

    assign gmii_rxd      = gmii_rxd_q;
    assign gmii_rx_dv    = gmii_dv_q;
    assign gmii_rx_er    = gmii_er_q;
    assign pay_valid     = pv_q;
    assign pay_data      = pd_q;
    assign pay_sof       = psof_q;
    assign pay_eof       = peof_q;
    assign pay_err       = perr_q;
    assign pay_len       = plen_q;
    assign frame_ok_cnt  = ok_cnt_q;
    assign frame_err_cnt = err_cnt_q;
    assign link_up       = link_up_q;
    assign link_speed    = link_speed_q;
    assign link_duplex   = link_duplex_q;

endmodule

// File: tb/tb_rgmii_gmii_rx.sv
// ---------------------------------------------------------------------------
// tb_rgmii_gmii_rx
//   Directed bench for rgmii_gmii_rx. Drives DDR nibbles around both clock
//   edges, watches the payload stream from a negedge monitor and compares
//   counts, lengths and counters with hand-computed values. The counter width
//   is reduced to 4 bits so saturation is reachable with a few bad frames.
// ---------------------------------------------------------------------------
module tb_rgmii_gmii_rx;

    localparam int CNT_W = 4;
    localparam int LEN_W = 16;

    logic             clk;
    logic             rst_n;
    logic [3:0]       rxd;
    logic             ctl;
    logic [7:0]       gmii_rxd;
    logic             gmii_rx_dv, gmii_rx_er;
    logic             pay_valid, pay_sof, pay_eof, pay_err;
    logic [7:0]       pay_data;
    logic [LEN_W-1:0] pay_len;
    logic [CNT_W-1:0] frame_ok_cnt, frame_err_cnt;
    logic             link_up, link_duplex;
    logic [1:0]       link_speed;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    int mon_nv = 0, mon_nsof = 0, mon_neof = 0, mon_seq_bad = 0, mon_orphan = 0;
    int mon_idx = 0;
    logic [7:0]       mon_eof_b = 8'h00;
    logic [LEN_W-1:0] mon_len   = '0;
    logic             mon_err   = 1'b0;

    int b_nv, b_nsof, b_neof, b_seq;
    int exp_ok, exp_err;

    rgmii_gmii_rx #(.CNT_W(CNT_W), .LEN_W(LEN_W), .MAX_LEN(1522)) dut (
        .rgmii_rxc     (clk),
        .rst_n         (rst_n),
        .rgmii_rxd     (rxd),
        .rgmii_rx_ctl  (ctl),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
        .pay_valid     (pay_valid),
        .pay_data      (pay_data),
        .pay_sof       (pay_sof),
        .pay_eof       (pay_eof),
        .pay_err       (pay_err),
        .pay_len       (pay_len),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt),
        .link_up       (link_up),
        .link_speed    (link_speed),
        .link_duplex   (link_duplex)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Payload monitor: sampled on the falling edge, away from register updates
    always @(negedge clk) begin
        if (rst_n) begin
            if ((pay_sof || pay_eof || pay_err) && !pay_valid) begin
                mon_orphan <= mon_orphan + 1;
            end
            if (pay_valid) begin
                if (pay_sof) begin
                    mon_nsof <= mon_nsof + 1;
                end
                if (pay_data != (pay_sof ? 8'h00 : mon_idx[7:0])) begin
                    mon_seq_bad <= mon_seq_bad + 1;
                end
                mon_idx <= pay_sof ? 1 : mon_idx + 1;
                mon_nv  <= mon_nv + 1;
                if (pay_eof) begin
                    mon_neof  <= mon_neof + 1;
                    mon_eof_b <= pay_data;
                    mon_len   <= pay_len;
                    mon_err   <= pay_err;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One GMII byte as two DDR nibbles
    task automatic drive(input logic [7:0] b, input logic dv, input logic er);
        @(negedge clk);
        #1;
        rxd = b[3:0];
        ctl = dv;
        @(posedge clk);
        #1;
        rxd = b[7:4];
        ctl = dv ^ er;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int len, input int er_idx, input int gap);
        for (int k = 0; k < 7; k++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < len; i++) drive(i[7:0], 1'b1, i == er_idx);
        idle(gap);
    endtask

    task automatic snap();
        b_nv   = mon_nv;
        b_nsof = mon_nsof;
        b_neof = mon_neof;
        b_seq  = mon_seq_bad;
    endtask

    initial begin
        rst_n = 1'b0;
        rxd   = 4'h0;
        ctl   = 1'b0;
        exp_ok  = 0;
        exp_err = 0;
        #20;
        check_eq("rst_gmii_rxd", gmii_rxd, 8'h00);
        check_eq("rst_dv", gmii_rx_dv, 1'b0);
        check_eq("rst_er", gmii_rx_er, 1'b0);
        check_eq("rst_pay_valid", pay_valid, 1'b0);
        check_eq("rst_pay_len", pay_len, 16'd0);
        check_eq("rst_ok_cnt", frame_ok_cnt, 4'd0);
        check_eq("rst_err_cnt", frame_err_cnt, 4'd0);
        check_eq("rst_link_up", link_up, 1'b0);
        check_eq("rst_link_speed", link_speed, 2'b10);
        check_eq("rst_link_duplex", link_duplex, 1'b1);

        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
`ifdef RGMII_RX_INBAND_EN
        // idle nibble 0x0 repeated: link down, 10M, half duplex
        check_eq("post_rst_link_up", link_up, 1'b0);
        check_eq("post_rst_speed", link_speed, 2'b00);
        check_eq("post_rst_duplex", link_duplex, 1'b0);
`else
        check_eq("post_rst_link_up", link_up, 1'b1);
        check_eq("post_rst_speed", link_speed, 2'b10);
        check_eq("post_rst_duplex", link_duplex, 1'b1);
`endif

        // DDR nibble assembly: rise 0xA, fall 0x5
        drive(8'h5A, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        check_eq("nib_byte", gmii_rxd, 8'h5A);
        check_eq("nib_dv", gmii_rx_dv, 1'b1);
        check_eq("nib_er", gmii_rx_er, 1'b0);
        drive(8'h5A, 1'b1, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        check_eq("nib_er_byte", gmii_rxd, 8'h5A);
        check_eq("nib_er_dv", gmii_rx_dv, 1'b1);
        check_eq("nib_er_er", gmii_rx_er, 1'b1);
        // each lone non-preamble byte is a dropped frame
        idle(4);
        exp_err = 2;
        check_eq("nib_err_cnt", frame_err_cnt, exp_err[3:0]);

        // Good 64-byte frame
        snap();
        send_frame(64, -1, 4);
        exp_ok = 1;
        check_eq("f64_nv", mon_nv - b_nv, 64);
        check_eq("f64_nsof", mon_nsof - b_nsof, 1);
        check_eq("f64_neof", mon_neof - b_neof, 1);
        check_eq("f64_seq", mon_seq_bad - b_seq, 0);
        check_eq("f64_eof_byte", mon_eof_b, 8'h3F);
        check_eq("f64_len", mon_len, 16'd64);
        check_eq("f64_err", mon_err, 1'b0);
        check_eq("f64_ok_cnt", frame_ok_cnt, exp_ok[3:0]);
        check_eq("f64_err_cnt", frame_err_cnt, exp_err[3:0]);

        // 20-byte frame with er on byte 10
        snap();
        send_frame(20, 10, 4);
        exp_err++;
        check_eq("fer_neof", mon_neof - b_neof, 1);
        check_eq("fer_len", mon_len, 16'd20);
        check_eq("fer_err", mon_err, 1'b1);
        check_eq("fer_err_cnt", frame_err_cnt, exp_err[3:0]);
        check_eq("fer_ok_cnt", frame_ok_cnt, exp_ok[3:0]);

        // Bad preamble, then a good frame
        snap();
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h17, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        drive(8'h01, 1'b1, 1'b0);
        idle(4);
        exp_err++;
        check_eq("bpre_nv", mon_nv - b_nv, 0);
        check_eq("bpre_err_cnt", frame_err_cnt, exp_err[3:0]);
        snap();
        send_frame(8, -1, 4);
        exp_ok++;
        check_eq("after_bpre_len", mon_len, 16'd8);
        check_eq("after_bpre_err", mon_err, 1'b0);
        check_eq("after_bpre_ok_cnt", frame_ok_cnt, exp_ok[3:0]);

        // SFD immediately followed by dv low
        snap();
        send_frame(0, -1, 4);
        exp_err++;
        check_eq("empty_nv", mon_nv - b_nv, 0);
        check_eq("empty_err_cnt", frame_err_cnt, exp_err[3:0]);

        // Single-byte frame: sof and eof on the same strobe
        snap();
        send_frame(1, -1, 4);
        exp_ok++;
        check_eq("one_nv", mon_nv - b_nv, 1);
        check_eq("one_nsof", mon_nsof - b_nsof, 1);
        check_eq("one_len", mon_len, 16'd1);
        check_eq("one_ok_cnt", frame_ok_cnt, exp_ok[3:0]);

        // Back-to-back frames with a single idle cycle between them
        snap();
        send_frame(5, -1, 1);
        send_frame(6, -1, 4);
        exp_ok += 2;
        check_eq("b2b_neof", mon_neof - b_neof, 2);
        check_eq("b2b_nv", mon_nv - b_nv, 11);
        check_eq("b2b_seq", mon_seq_bad - b_seq, 0);
        check_eq("b2b_len", mon_len, 16'd6);
        check_eq("b2b_ok_cnt", frame_ok_cnt, exp_ok[3:0]);

        // Exactly MAX_LEN is good, 1600 is oversize
        send_frame(1522, -1, 4);
        exp_ok++;
        check_eq("max_len", mon_len, 16'd1522);
        check_eq("max_err", mon_err, 1'b0);
        check_eq("max_ok_cnt", frame_ok_cnt, exp_ok[3:0]);
        send_frame(1600, -1, 4);
        exp_err++;
        check_eq("big_len", mon_len, 16'd1600);
        check_eq("big_err", mon_err, 1'b1);
        check_eq("big_err_cnt", frame_err_cnt, exp_err[3:0]);

        // Drive the error counter to all-ones, then one more bad frame
        while (exp_err < 15) begin
            drive(8'h17, 1'b1, 1'b0);
            idle(2);
            exp_err++;
        end
        idle(2);
        check_eq("sat_reach", frame_err_cnt, 4'hF);
        drive(8'h17, 1'b1, 1'b0);
        idle(4);
        check_eq("sat_hold", frame_err_cnt, 4'hF);
        check_eq("sat_ok_cnt", frame_ok_cnt, exp_ok[3:0]);

`ifdef RGMII_RX_INBAND_EN
        // In-band status nibble decode with debounce
        for (int k = 0; k < 4; k++) drive(8'h0D, 1'b0, 1'b0);
        idle(0);
        drive(8'h0D, 1'b0, 1'b0);
        drive(8'h0D, 1'b0, 1'b0);
        check_eq("ib_up", link_up, 1'b1);
        check_eq("ib_speed", link_speed, 2'b10);
        check_eq("ib_duplex", link_duplex, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) drive(8'h0D, 1'b0, 1'b0);
        check_eq("ib_glitch_up", link_up, 1'b1);
        check_eq("ib_glitch_duplex", link_duplex, 1'b1);
        for (int k = 0; k < 4; k++) drive(8'h07, 1'b0, 1'b0);
        check_eq("ib_code11_speed", link_speed, 2'b10);
        check_eq("ib_code11_duplex", link_duplex, 1'b1);
        for (int k = 0; k < 4; k++) drive(8'h00, 1'b0, 1'b0);
        check_eq("ib_down", link_up, 1'b0);
`else
        check_eq("fixed_link_up", link_up, 1'b1);
`endif

        // Reset in the middle of a frame
        snap();
        for (int k = 0; k < 7; k++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(i[7:0], 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_ok_cnt", frame_ok_cnt, 4'd0);
        check_eq("mid_rst_err_cnt", frame_err_cnt, 4'd0);
        check_eq("mid_rst_pay_valid", pay_valid, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        ctl = 1'b0;
        idle(6);
        check_eq("mid_rst_neof", mon_neof - b_neof, 0);
        check_eq("mid_rst_ok_after", frame_ok_cnt, 4'd0);
        check_eq("mid_rst_err_after", frame_err_cnt, 4'd0);

        check_eq("orphan_marks", mon_orphan, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
